// File: rtl/fsm_interval_timer_pkg.sv
// ----------------------------------------------------------------------------
// fsm_timer_pkg
//
// Shared types and defaults for the traffic-light interval timer.
//
// Contents:
//   timerState_t    - timer FSM state (RUN counting, DONE both intervals hit)
//   DEF_PRESCALE    - clk cycles per tick (nominally 1 s at 50 MHz)
//   DEF_CNT_W       - width of the tick counter and length inputs
//   DEF_SHORT_TICKS - short interval used after reset
//   DEF_LONG_TICKS  - long interval used after reset
//   nonZeroLen()    - replaces a zero interval length with 1
// ----------------------------------------------------------------------------
package fsm_timer_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } timerState_t;

    localparam int DEF_PRESCALE    = 50000000;
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_SHORT_TICKS = 5;
    localparam int DEF_LONG_TICKS  = 25;

    // A zero-length interval would mean "elapsed before it started"; treat it
    // as the shortest real interval instead. Lengths are passed zero-extended
    // to 32 bits so one function serves any counter width up to 32.
    function automatic logic [31:0] nonZeroLen(input logic [31:0] len);
        return (len == 32'd0) ? 32'd1 : len;
    endfunction

endpackage

// File: rtl/fsm_interval_timer_tick_gen.sv
// ----------------------------------------------------------------------------
// tick_gen
//
// Prescaler for the interval timer. Counts clk cycles while enabled and emits
// a single-cycle tick in the cycle where the prescaler holds PRESCALE-1, so the
// parent counter advances on the same edge at which the prescaler wraps.
//
// Parameters:
//   PRESCALE - clk cycles per tick, minimum 1 (1 => tick every enabled cycle)
//
// Ports:
//   clk   in  system clock, rising edge
//   rst_n in  asynchronous active-low reset
//   clr   in  synchronous clear (start timer); wins over en
//   en    in  count enable (timer running and not held)
//   tick  out one-cycle pulse, combinational from the prescaler register
// ----------------------------------------------------------------------------
module tick_gen
    import fsm_timer_pkg::*;
#(
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    // A width of at least one bit keeps PRESCALE=1 legal; the register then
    // sits at 0 permanently and every enabled cycle is a tick.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] preCnt;

    assign tick = en && !clr && (preCnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            preCnt <= '0;
        end else if (clr) begin
            preCnt <= '0;
        end else if (en) begin
            if (preCnt == LAST) begin
                preCnt <= '0;
            end else begin
                preCnt <= preCnt + PW'(1);
            end
        end
    end

endmodule

// File: rtl/fsm_interval_timer.sv
// ----------------------------------------------------------------------------
// fsm_interval_timer
//
// Interval timer on the far side of the traffic-light controller's timer
// handshake. The controller pulses ST on every light change; this block
// latches the short/long lengths, counts prescaled ticks and raises TS / TL
// when each interval has elapsed. TS and TL stay high until the next ST.
//
// Handshake: ST is a level sampled on every clk edge and acts as a
// synchronous clear-and-restart that overrides everything else (including
// hold). TS/TL are sticky status flags, not pulses; the controller may sample
// them whenever it likes. TL always implies TS.
//
// Optional feature (macro FSM_TIMER_HOLD_EN): adds input 'hold'. hold=1 with
// ST=0 freezes prescaler and count and leaves TS, TL and state untouched
// (emergency / all-red override). Without the macro the port does not exist.
//
// Parameters:
//   PRESCALE  - clk cycles per tick (>= 1)
//   CNT_W     - tick counter / length width (<= 32)
//   DEF_SHORT - short length in ticks after reset
//   DEF_LONG  - long length in ticks after reset
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   ST        in   start/restart timer
//   short_i   in   short length in ticks, sampled when ST=1 (0 => 1)
//   long_i    in   long length in ticks, sampled when ST=1 (0 => 1)
//   hold      in   freeze counting (only with FSM_TIMER_HOLD_EN)
//   TS        out  short interval elapsed (sticky)
//   TL        out  long interval elapsed (sticky)
//   busy      out  high while in RUN
//   elapsed_o out  ticks counted since last ST (saturating)
//   stateDbg  out  current FSM state, for observation
// ----------------------------------------------------------------------------
module fsm_interval_timer
    import fsm_timer_pkg::*;
#(
    parameter int PRESCALE  = DEF_PRESCALE,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int DEF_SHORT = DEF_SHORT_TICKS,
    parameter int DEF_LONG  = DEF_LONG_TICKS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ST,
    input  logic [CNT_W-1:0] short_i,
    input  logic [CNT_W-1:0] long_i,
`ifdef FSM_TIMER_HOLD_EN
    input  logic             hold,
`endif
    output logic             TS,
    output logic             TL,
    output logic             busy,
    output logic [CNT_W-1:0] elapsed_o,
    output timerState_t      stateDbg
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    timerState_t      state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] shortLen;
    logic [CNT_W-1:0] longLen;
    logic [CNT_W-1:0] countNext;
    logic             freeze;
    logic             tickEn;
    logic             tick;
    logic             reachShort;
    logic             reachLong;

`ifdef FSM_TIMER_HOLD_EN
    assign freeze = hold;
`else
    assign freeze = 1'b0;
`endif

    // Once TL is up the interval is over; stop the prescaler so it holds
    // its value through the transition to DONE.
    assign tickEn = (state == RUN) && !freeze && !TL;

    tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tickGen (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (ST),
        .en   (tickEn),
        .tick (tick)
    );

    // Saturating increment; the flags compare against the post-increment
    // value so they rise on the very edge the count reaches the length.
    assign countNext  = (tick && (count != CNT_MAX)) ? count + CNT_W'(1) : count;
    assign reachShort = (countNext >= shortLen);
    assign reachLong  = (countNext >= longLen);

    assign elapsed_o = count;
    assign stateDbg  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            count    <= '0;
            TS       <= 1'b0;
            TL       <= 1'b0;
            busy     <= 1'b1;
            shortLen <= CNT_W'(DEF_SHORT);
            longLen  <= CNT_W'(DEF_LONG);
        end else if (ST) begin
            state    <= RUN;
            count    <= '0;
            TS       <= 1'b0;
            TL       <= 1'b0;
            busy     <= 1'b1;
            shortLen <= CNT_W'(nonZeroLen(32'(short_i)));
            longLen  <= CNT_W'(nonZeroLen(32'(long_i)));
        end else begin
            case (state)
                RUN: begin
                    if (!freeze) begin
                        count <= countNext;
                        // TL drags TS with it when long_len <= short_len.
                        if (reachLong) begin
                            TL <= 1'b1;
                            TS <= 1'b1;
                        end else if (reachShort) begin
                            TS <= 1'b1;
                        end
                        if (TS && TL) begin
                            state <= DONE;
                            busy  <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    // Everything frozen until the next ST.
                    busy <= 1'b0;
                end
                default: begin
                    state <= RUN;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_interval_timer.sv
// ----------------------------------------------------------------------------
// tb_fsm_interval_timer
//
// Directed bench for fsm_interval_timer with PRESCALE=4, CNT_W=8,
// DEF_SHORT=2, DEF_LONG=5. Expected edge numbers are hand-computed: with
// PRESCALE=4 the count reaches N at 4*N edges after the ST edge (or after
// reset release). Build with +define+FSM_TIMER_HOLD_EN to add the hold tests.
// ----------------------------------------------------------------------------
module tb_fsm_interval_timer;
    import fsm_timer_pkg::*;

    localparam int PRESCALE  = 4;
    localparam int CNT_W     = 8;
    localparam int DEF_SHORT = 2;
    localparam int DEF_LONG  = 5;

    // ---------------- clock / reset ----------------
    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             ST    = 1'b0;
    logic [CNT_W-1:0] short_i = '0;
    logic [CNT_W-1:0] long_i  = '0;
`ifdef FSM_TIMER_HOLD_EN
    logic             hold  = 1'b0;
`endif
    logic             TS;
    logic             TL;
    logic             busy;
    logic [CNT_W-1:0] elapsed_o;
    timerState_t      stateDbg;

    always #5 clk = ~clk;

    fsm_interval_timer #(
        .PRESCALE (PRESCALE),
        .CNT_W    (CNT_W),
        .DEF_SHORT(DEF_SHORT),
        .DEF_LONG (DEF_LONG)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ST       (ST),
        .short_i  (short_i),
        .long_i   (long_i),
`ifdef FSM_TIMER_HOLD_EN
        .hold     (hold),
`endif
        .TS       (TS),
        .TL       (TL),
        .busy     (busy),
        .elapsed_o(elapsed_o),
        .stateDbg (stateDbg)
    );

    // ---------------- scoreboard ----------------
    int compared   = 0;
    int mismatched = 0;
    logic [31:0] exp_q[$];

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance one active edge and sample 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle ST with the given lengths; afterwards the length inputs are
    // scribbled to 1/1, which the timer must ignore.
    task automatic pulseStart(input logic [CNT_W-1:0] s, input logic [CNT_W-1:0] l);
        ST      = 1'b1;
        short_i = s;
        long_i  = l;
        step();
        ST      = 1'b0;
        short_i = 8'd1;
        long_i  = 8'd1;
    endtask

    function automatic bit sel(input int which);
        case (which)
            0:       return TS;
            1:       return TL;
            default: return !busy;
        endcase
    endfunction

    // Edges until the selected condition is true; maxEdges+1 on timeout so the
    // caller's edge check reports it.
    task automatic waitFor(input int which, input int maxEdges, output int n);
        n = maxEdges + 1;
        for (int i = 1; i <= maxEdges; i++) begin
            step();
            if (sel(which)) begin
                n = i;
                return;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    int n;
    int tsEdge;
    int tlEdge;
    logic [CNT_W-1:0] prev;

    initial begin
        // Reset values
        rst_n = 1'b0;
        repeat (3) step();
        checkVal("rst_ts", TS, 0);
        checkVal("rst_tl", TL, 0);
        checkVal("rst_busy", busy, 1);
        checkVal("rst_elapsed", elapsed_o, 0);
        checkVal("rst_state", stateDbg, RUN);

        // Free run with default lengths straight out of reset
        rst_n = 1'b1;
        waitFor(0, 40, n);
        checkVal("def_ts_edge", n, 8);
        checkVal("def_ts_tl_low", TL, 0);
        checkVal("def_ts_elapsed", elapsed_o, 2);
        waitFor(1, 40, n);
        checkVal("def_tl_edge", 8 + n, 20);
        checkVal("def_tl_busy", busy, 1);
        waitFor(2, 10, n);
        checkVal("def_busy_edge", 20 + n, 21);
        checkVal("def_done_state", stateDbg, DONE);
        repeat (6) step();
        checkVal("def_done_elapsed", elapsed_o, 5);
        checkVal("def_done_flags", {TS, TL}, 2'b11);

        // Restart from DONE with 3/6, tracking the count progression
        pulseStart(8'd3, 8'd6);
        checkVal("st_clear_flags", {TS, TL}, 2'b00);
        checkVal("st_clear_busy", busy, 1);
        checkVal("st_clear_elapsed", elapsed_o, 0);
        for (int v = 1; v <= 6; v++) exp_q.push_back(32'(v));
        prev = '0;
        tsEdge = 0;
        tlEdge = 0;
        for (int e = 1; e <= 40; e++) begin
            step();
            if (elapsed_o != prev && exp_q.size() > 0) begin
                checkVal("st_elapsed_seq", elapsed_o, exp_q.pop_front());
                prev = elapsed_o;
            end
            if (TS && tsEdge == 0) tsEdge = e;
            if (TL) begin
                tlEdge = e;
                break;
            end
        end
        checkVal("st36_ts_edge", tsEdge, 12);
        checkVal("st36_tl_edge", tlEdge, 24);
        checkVal("st36_seq_left", exp_q.size(), 0);

        // long <= short: both flags together at the long length
        pulseStart(8'd7, 8'd4);
        waitFor(0, 40, n);
        checkVal("st74_ts_edge", n, 16);
        checkVal("st74_tl_with_ts", TL, 1);
        checkVal("st74_elapsed", elapsed_o, 4);

        // Zero lengths behave as 1
        pulseStart(8'd0, 8'd0);
        waitFor(1, 20, n);
        checkVal("st00_tl_edge", n, 4);
        checkVal("st00_ts", TS, 1);
        checkVal("st00_elapsed", elapsed_o, 1);

        // ST held for 10 cycles keeps the timer cleared
        ST      = 1'b1;
        short_i = 8'd2;
        long_i  = 8'd3;
        for (int i = 0; i < 10; i++) begin
            step();
            checkVal("sthold_elapsed", elapsed_o, 0);
            checkVal("sthold_flags", {TS, TL}, 2'b00);
            checkVal("sthold_busy", busy, 1);
        end
        ST = 1'b0;
        waitFor(0, 40, n);
        checkVal("sthold_ts_edge", n, 8);
        checkVal("sthold_elapsed_ts", elapsed_o, 2);

        // Asynchronous reset mid-count, then defaults again
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        checkVal("midrst_flags", {TS, TL}, 2'b00);
        checkVal("midrst_busy", busy, 1);
        checkVal("midrst_elapsed", elapsed_o, 0);
        step();
        rst_n = 1'b1;
        waitFor(0, 40, n);
        checkVal("midrst_ts_edge", n, 8);
        waitFor(1, 40, n);
        checkVal("midrst_tl_edge", 8 + n, 20);

`ifdef FSM_TIMER_HOLD_EN
        // hold for 9 edges mid-count delays TS by 9 edges
        pulseStart(8'd3, 8'd6);
        repeat (4) step();
        checkVal("hold_pre_elapsed", elapsed_o, 1);
        hold = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            checkVal("hold_frozen_elapsed", elapsed_o, 1);
            checkVal("hold_frozen_busy", busy, 1);
        end
        hold = 1'b0;
        waitFor(0, 40, n);
        checkVal("hold_ts_edge", 13 + n, 21);

        // ST during hold still clears; counting resumes once hold drops
        hold    = 1'b1;
        pulseStart(8'd3, 8'd6);
        checkVal("hold_st_elapsed", elapsed_o, 0);
        checkVal("hold_st_flags", {TS, TL}, 2'b00);
        checkVal("hold_st_busy", busy, 1);
        repeat (4) step();
        checkVal("hold_st_frozen", elapsed_o, 0);
        hold = 1'b0;
        waitFor(0, 40, n);
        checkVal("hold_st_ts_edge", 5 + n, 17);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Global time limit
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "time limit reached");
    end

endmodule
